// File: rtl/pll_reset_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
// State encoding of the sequencer FSM, lock-loss counter limit and a
// counter-width helper that never returns a zero-width vector.
package pll_reset_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } seq_state_e;

    localparam logic [7:0] LOST_CNT_MAX = 8'hFF;

    // Bits needed to count 0 .. n-1; at least one bit so n == 1 still works.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_ff2.sv
// Two-flop synchronizer for a single asynchronous level signal.
// Both flops clear to 0 under the synchronous active-low reset.
module sync_ff2 (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Shift the asynchronous input through two flops to settle metastability.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_seq.sv
// PLL reset sequencer: waits for a stable PLL lock, holds the downstream
// reset for a fixed time, then releases it and watches for lock loss.
// Optional board-button debounce is compiled in with PLL_RESET_SEQ_DEBOUNCE_EN;
// without it the synchronized button level is used directly.
module pll_reset_seq
    import pll_reset_seq_pkg::*;
#(
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned RST_HOLD_CYCLES    = 16,
    parameter int unsigned DEBOUNCE_CYCLES    = 65536
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       ext_rst_n,
    output logic       sys_rst_n,
    output logic [1:0] seq_state,
    output logic [7:0] lock_lost_cnt
);

    localparam int unsigned MAX_CYCLES = (LOCK_STABLE_CYCLES > RST_HOLD_CYCLES) ?
                                         LOCK_STABLE_CYCLES : RST_HOLD_CYCLES;
    localparam int unsigned CNT_W      = cnt_width(MAX_CYCLES);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_HOLD_CYCLES - 1);

    if (LOCK_STABLE_CYCLES < 1 || RST_HOLD_CYCLES < 1 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
        $error("pll_reset_seq: cycle parameters must be at least 1");
    end

    logic       locked_s;
    logic       ext_s;
    logic       ext_f;
    logic       seq_ok;

    seq_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sys_rst_n_q;
    logic [7:0]       lost_q;

    sync_ff2 u_sync_locked (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .d_i    (pll_locked),
        .q_o    (locked_s)
    );

    sync_ff2 u_sync_ext (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .d_i    (ext_rst_n),
        .q_o    (ext_s)
    );

`ifdef PLL_RESET_SEQ_DEBOUNCE_EN
    localparam int unsigned DEB_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    logic [DEB_W-1:0] deb_cnt_q;
    logic             ext_f_q;

    // Accept a new button level only after it has held for the whole window.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            deb_cnt_q <= '0;
            ext_f_q   <= 1'b0;
        end else if (ext_s == ext_f_q) begin
            deb_cnt_q <= '0;
        end else if (deb_cnt_q == DEB_LAST) begin
            deb_cnt_q <= '0;
            ext_f_q   <= ext_s;
        end else begin
            deb_cnt_q <= deb_cnt_q + 1'b1;
        end
    end

    assign ext_f = ext_f_q;
`else
    assign ext_f = ext_s;
`endif

    assign seq_ok = locked_s && ext_f;

    // Sequencer FSM with its phase counter, registered reset output and lock-loss counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= WAIT_LOCK;
            cnt_q       <= '0;
            sys_rst_n_q <= 1'b0;
            lost_q      <= '0;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    if (seq_ok) begin
                        state_q <= STABLE;
                        cnt_q   <= '0;
                    end
                end
                STABLE: begin
                    if (!seq_ok) begin
                        state_q <= WAIT_LOCK;
                        cnt_q   <= '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_q <= HOLD;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (!seq_ok) begin
                        state_q <= WAIT_LOCK;
                        cnt_q   <= '0;
                    end else if (cnt_q == HOLD_LAST) begin
                        state_q     <= RUN;
                        cnt_q       <= '0;
                        sys_rst_n_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    if (!seq_ok) begin
                        state_q     <= WAIT_LOCK;
                        cnt_q       <= '0;
                        sys_rst_n_q <= 1'b0;
                        if (!locked_s && lost_q != LOST_CNT_MAX) begin
                            lost_q <= lost_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q     <= WAIT_LOCK;
                    cnt_q       <= '0;
                    sys_rst_n_q <= 1'b0;
                end
            endcase
        end
    end

    assign sys_rst_n     = sys_rst_n_q;
    assign seq_state     = state_q;
    assign lock_lost_cnt = lost_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Self-checking bench for pll_reset_seq with L=4, H=2, debounce window 8.
// Follows PLL_RESET_SEQ_DEBOUNCE_EN the same way the design does.
module tb_pll_reset_seq;

    localparam int L   = 4;
    localparam int H   = 2;
    localparam int DEB = 8;
    localparam int RUN_STREAK = L + H + 1;
`ifdef PLL_RESET_SEQ_DEBOUNCE_EN
    localparam bit DEB_ON = 1'b1;
`else
    localparam bit DEB_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       ext_rst_n = 1'b0;
    logic       sys_rst_n;
    logic [1:0] seq_state;
    logic [7:0] lock_lost_cnt;

    int vectors = 0;
    int miscompares = 0;

    pll_reset_seq #(
        .LOCK_STABLE_CYCLES (L),
        .RST_HOLD_CYCLES    (H),
        .DEBOUNCE_CYCLES    (DEB)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pll_locked    (pll_locked),
        .ext_rst_n     (ext_rst_n),
        .sys_rst_n     (sys_rst_n),
        .seq_state     (seq_state),
        .lock_lost_cnt (lock_lost_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: the sequence position is the number of consecutive
    // edges at which lock and filtered button were both good.
    bit       m_ls1, m_ls2, m_es1, m_es2, m_ef;
    bit       m_hist[$];
    int       m_streak = 0;
    int       m_cnt = 0;
    logic [1:0] m_state;
    logic       m_sys;
    bit       m_good, m_fe, m_all_diff;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_ls1 = 0; m_ls2 = 0; m_es1 = 0; m_es2 = 0; m_ef = 0;
            m_hist.delete();
            m_streak = 0;
            m_cnt = 0;
        end else begin
            m_fe = DEB_ON ? m_ef : m_es2;
            m_good = m_ls2 && m_fe;
            if (m_good) begin
                if (m_streak < RUN_STREAK) m_streak++;
            end else begin
                if (m_streak >= RUN_STREAK && !m_ls2 && m_cnt < 255) m_cnt++;
                m_streak = 0;
            end
            m_hist.push_back(m_es2);
            if (m_hist.size() > DEB) void'(m_hist.pop_front());
            if (m_hist.size() == DEB) begin
                m_all_diff = 1;
                foreach (m_hist[i]) if (m_hist[i] == m_ef) m_all_diff = 0;
                if (m_all_diff) m_ef = m_es2;
            end
            m_ls2 = m_ls1; m_ls1 = pll_locked;
            m_es2 = m_es1; m_es1 = ext_rst_n;
        end
        m_sys   = (m_streak >= RUN_STREAK);
        m_state = (m_streak == 0) ? 2'd0 : (m_streak <= L) ? 2'd1 :
                  (m_streak <= L + H) ? 2'd2 : 2'd3;
    end

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 0; pll_locked = 0; ext_rst_n = 1;
        settle(2);
        rst_n = 1;
        settle(DEB + 6);
    endtask

    task automatic test_reset();
        rst_n = 0;
        pll_locked = 1'($urandom);
        ext_rst_n = 1'($urandom);
        settle(3);
        vectors++;
        if ({sys_rst_n, seq_state, lock_lost_cnt} !== 11'b0) begin
            miscompares++;
            $display("FAIL reset_state: got sys=%b st=%0d cnt=%0d, want 0/0/0", sys_rst_n, seq_state, lock_lost_cnt);
        end
    endtask

    task automatic test_power_up();
        logic [1:0] exp_st;
        rst_n = 1; pll_locked = 0; ext_rst_n = 1;
        settle(DEB + 6);
        pll_locked = 1;
        for (int e = 1; e <= 12; e++) begin
            @(negedge clk);
            exp_st = (e < 3) ? 2'd0 : (e < 3 + L) ? 2'd1 : (e < 3 + L + H) ? 2'd2 : 2'd3;
            vectors++;
            if (seq_state !== exp_st || sys_rst_n !== (e >= 3 + L + H) || lock_lost_cnt !== 8'd0) begin
                miscompares++;
                $display("FAIL power_up edge %0d: got sys=%b st=%0d cnt=%0d, want sys=%b st=%0d cnt=0",
                         e, sys_rst_n, seq_state, lock_lost_cnt, (e >= 3 + L + H), exp_st);
            end
        end
    endtask

    task automatic test_lock_loss();
        logic [1:0] exp_st;
        logic       exp_sys;
        pll_locked = 0;
        for (int e = 1; e <= 14; e++) begin
            @(negedge clk);
            exp_st  = (e <= 2) ? 2'd3 : (e <= 5) ? 2'd0 : (e <= 9) ? 2'd1 : (e <= 11) ? 2'd2 : 2'd3;
            exp_sys = (e <= 2) || (e >= 12);
            vectors++;
            if (seq_state !== exp_st || sys_rst_n !== exp_sys || lock_lost_cnt !== ((e >= 3) ? 8'd1 : 8'd0)) begin
                miscompares++;
                $display("FAIL lock_loss edge %0d: got sys=%b st=%0d cnt=%0d, want sys=%b st=%0d",
                         e, sys_rst_n, seq_state, lock_lost_cnt, exp_sys, exp_st);
            end
            if (e == 3) pll_locked = 1;
        end
    endtask

    task automatic test_stable_drop();
        logic [1:0] exp_st;
        do_reset();
        pll_locked = 1;
        for (int e = 1; e <= 14; e++) begin
            @(negedge clk);
            exp_st = (e <= 2) ? 2'd0 : (e <= 5) ? 2'd1 : (e == 6) ? 2'd0 :
                     (e <= 10) ? 2'd1 : (e <= 12) ? 2'd2 : 2'd3;
            vectors++;
            if (seq_state !== exp_st || sys_rst_n !== (e >= 13) || lock_lost_cnt !== 8'd0) begin
                miscompares++;
                $display("FAIL stable_drop edge %0d: got sys=%b st=%0d cnt=%0d, want sys=%b st=%0d cnt=0",
                         e, sys_rst_n, seq_state, lock_lost_cnt, (e >= 13), exp_st);
            end
            if (e == 3) pll_locked = 0;
            if (e == 4) pll_locked = 1;
        end
    endtask

    task automatic test_saturation();
        int exp_cnt;
        int budget;
        for (int i = 0; i < 300; i++) begin
            budget = 0;
            while (!m_sys && budget < 40) begin
                @(negedge clk);
                budget++;
                vectors++;
                if ({sys_rst_n, seq_state, lock_lost_cnt} !== {m_sys, m_state, 8'(m_cnt)}) begin
                    miscompares++;
                    $display("FAIL saturation_seq: got %b/%0d/%0d, want %b/%0d/%0d",
                             sys_rst_n, seq_state, lock_lost_cnt, m_sys, m_state, m_cnt);
                end
            end
            if (!m_sys) begin
                miscompares++;
                $display("FAIL saturation_timeout: no RUN after 40 cycles, iteration %0d", i);
            end
            pll_locked = 0;
            settle(3);
            exp_cnt = (i + 1 > 255) ? 255 : i + 1;
            vectors++;
            if (lock_lost_cnt !== 8'(exp_cnt) || sys_rst_n !== 1'b0) begin
                miscompares++;
                $display("FAIL saturation_count iter %0d: got cnt=%0d sys=%b, want cnt=%0d sys=0",
                         i, lock_lost_cnt, sys_rst_n, exp_cnt);
            end
            pll_locked = 1;
        end
    endtask

    task automatic test_ext_glitch();
        bit saw_wait;
        int glitch_len;
        do_reset();
        pll_locked = 1;
        for (int g = 0; g < 2; g++) begin
            glitch_len = (g == 0) ? 5 : 10;
            settle(3 + L + H + 2);
            saw_wait = 0;
            ext_rst_n = 0;
            for (int c = 0; c < 30; c++) begin
                @(negedge clk);
                if (c == glitch_len - 1) ext_rst_n = 1;
                if (seq_state === 2'd0) saw_wait = 1;
                vectors++;
                if ({sys_rst_n, seq_state, lock_lost_cnt} !== {m_sys, m_state, 8'(m_cnt)}) begin
                    miscompares++;
                    $display("FAIL ext_glitch_seq len %0d: got %b/%0d/%0d, want %b/%0d/%0d",
                             glitch_len, sys_rst_n, seq_state, lock_lost_cnt, m_sys, m_state, m_cnt);
                end
            end
            vectors++;
            if (saw_wait !== ((g == 1) || !DEB_ON) || lock_lost_cnt !== 8'd0) begin
                miscompares++;
                $display("FAIL ext_glitch len %0d: got left_run=%b cnt=%0d, want left_run=%b cnt=0",
                         glitch_len, saw_wait, lock_lost_cnt, ((g == 1) || !DEB_ON));
            end
        end
    endtask

    task automatic test_reset_in_hold();
        int budget;
        settle(3 + L + H + DEB + 4);
        pll_locked = 0;
        settle(5);
        pll_locked = 1;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            if (e == 7) begin
                vectors++;
                if (seq_state !== 2'd2 || lock_lost_cnt !== 8'd1) begin
                    miscompares++;
                    $display("FAIL hold_before_reset: got st=%0d cnt=%0d, want st=2 cnt=1", seq_state, lock_lost_cnt);
                end
                rst_n = 0;
            end
            if (e == 8) begin
                vectors++;
                if ({sys_rst_n, seq_state, lock_lost_cnt} !== 11'b0) begin
                    miscompares++;
                    $display("FAIL hold_reset: got sys=%b st=%0d cnt=%0d, want 0/0/0", sys_rst_n, seq_state, lock_lost_cnt);
                end
                rst_n = 1;
            end
        end
        budget = 0;
        while (sys_rst_n !== 1'b1 && budget < 60) begin
            @(negedge clk);
            budget++;
            vectors++;
            if ({sys_rst_n, seq_state, lock_lost_cnt} !== {m_sys, m_state, 8'(m_cnt)}) begin
                miscompares++;
                $display("FAIL hold_restart_seq: got %b/%0d/%0d, want %b/%0d/%0d",
                         sys_rst_n, seq_state, lock_lost_cnt, m_sys, m_state, m_cnt);
            end
        end
        if (sys_rst_n !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_restart: sys_rst_n=%b after 60 cycles, want 1", sys_rst_n);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            vectors++;
            if ({sys_rst_n, seq_state, lock_lost_cnt} !== {m_sys, m_state, 8'(m_cnt)}) begin
                miscompares++;
                $display("FAIL random cycle %0d: got %b/%0d/%0d, want %b/%0d/%0d",
                         c, sys_rst_n, seq_state, lock_lost_cnt, m_sys, m_state, m_cnt);
            end
            if (pll_locked) pll_locked = ($urandom_range(0, 24) != 0);
            else            pll_locked = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 39) == 0) ext_rst_n = ~ext_rst_n;
            else if (!ext_rst_n && $urandom_range(0, 5) == 0) ext_rst_n = 1;
            rst_n = ($urandom_range(0, 299) != 0);
        end
        rst_n = 1;
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_lock_loss();
        test_stable_drop();
        test_saturation();
        test_ext_glitch();
        test_reset_in_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
